pe_operand_joiner: RTL and testbench

Upstream operand-pairing stage for the integer processing element. It accepts two independent operand streams, each with a valid/ready handshake, and buffers each stream in its own small FIFO. It issues an aligned operand pair plus opcode only when both FIFOs hold data and issue is enabled. This guarantees the PE sees both input valids in the same cycle. Output is registered and drives the PE operand, valid and op inputs directly.

---
 rtl/pe_operand_joiner_pkg.sv | 20 ++
 rtl/pe_operand_joiner_if.sv | 37 +++
 rtl/pe_operand_joiner_fifo.sv | 37 +++
 rtl/pe_operand_joiner.sv | 67 ++++++
 tb/tb_pe_operand_joiner.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_operand_joiner_pkg.sv
// Shared widths, opcode encoding and FIFO-1 entry layout for the PE operand joiner.
package pe_operand_joiner_pkg;
    localparam int dwidth_double = 64;
    localparam int dwidth_int    = 32;

    typedef logic [1:0] op_t;
    localparam op_t OP_ADD     = 2'b00;
    localparam op_t OP_SUB     = 2'b01;
    localparam int  OP_MUL_BIT = 1;

    // Stream-1 entry: opcode rides along with operand 1
    typedef struct packed {
        op_t                      op;
        logic [dwidth_double-1:0] data;
    } opnd1_t;

    function automatic logic is_mul(input op_t op);
        return op[OP_MUL_BIT];
    endfunction
endpackage

// File: rtl/pe_operand_joiner_if.sv
// Operand-stream, issue-control and PE-facing signal bundle of the joiner.
interface pe_operand_joiner_if #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) ();
    import pe_operand_joiner_pkg::*;
    localparam int FW = $clog2(DEPTH) + 1;

    logic [dwidth_double-1:0] in1_data;
    op_t                      in1_op;
    logic                     in1_valid;
    logic                     in1_ready;
    logic [dwidth_double-1:0] in2_data;
    logic                     in2_valid;
    logic                     in2_ready;
    logic                     issue_en;
    logic [dwidth_double-1:0] out_inp1;
    logic [dwidth_double-1:0] out_inp2;
    logic                     out_valid1;
    logic                     out_valid2;
    op_t                      out_op;
    logic [FW-1:0]            fill1;
    logic [FW-1:0]            fill2;
    logic [CNT_W-1:0]         pair_count;

    modport slave (
        input  in1_data, in1_op, in1_valid, in2_data, in2_valid, issue_en,
        output in1_ready, in2_ready, out_inp1, out_inp2, out_valid1, out_valid2,
               out_op, fill1, fill2, pair_count
    );

    modport master (
        output in1_data, in1_op, in1_valid, in2_data, in2_valid, issue_en,
        input  in1_ready, in2_ready, out_inp1, out_inp2, out_valid1, out_valid2,
               out_op, fill1, fill2, pair_count
    );
endinterface

// File: rtl/pe_operand_joiner_fifo.sv
// Synchronous circular FIFO with occupancy output; caller guards push/pop, no bypass.
module pe_operand_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     fill
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fill <= fill + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign rdata = mem[rd_ptr];
endmodule

// File: rtl/pe_operand_joiner.sv
// Pairs two buffered operand streams and issues aligned operand pairs to the PE.
module pe_operand_joiner
    import pe_operand_joiner_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input logic                 clk,
    input logic                 rst,
    pe_operand_joiner_if.slave  io
);
    localparam int FW = $clog2(DEPTH) + 1;

    logic [FW-1:0]            fill1, fill2;
    logic                     push1, push2, pop;
    opnd1_t                   wdata1, head1;
    logic [dwidth_double-1:0] head2;
    logic                     vld_q;
    logic [dwidth_double-1:0] inp1_q, inp2_q;
    op_t                      op_q;
    logic [CNT_W-1:0]         cnt_q;

    // Ready is a pure occupancy compare: a pop at full frees space only next cycle
    assign io.in1_ready = !rst && (fill1 < FW'(DEPTH));
    assign io.in2_ready = !rst && (fill2 < FW'(DEPTH));
    assign push1  = io.in1_valid && io.in1_ready;
    assign push2  = io.in2_valid && io.in2_ready;
    assign pop    = io.issue_en && (fill1 != '0) && (fill2 != '0);
    assign wdata1 = '{op: io.in1_op, data: io.in1_data};

    pe_operand_fifo #(.W(dwidth_double + 2), .DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .rst(rst), .push(push1), .wdata(wdata1),
        .pop(pop), .rdata(head1), .fill(fill1)
    );

    pe_operand_fifo #(.W(dwidth_double), .DEPTH(DEPTH)) u_fifo2 (
        .clk(clk), .rst(rst), .push(push2), .wdata(io.in2_data),
        .pop(pop), .rdata(head2), .fill(fill2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            inp1_q <= '0;
            inp2_q <= '0;
            op_q   <= OP_ADD;
            cnt_q  <= '0;
        end else begin
            vld_q <= pop;
            if (pop) begin
                inp1_q <= head1.data;
                op_q   <= head1.op;
                inp2_q <= head2;
                cnt_q  <= cnt_q + 1'b1;
            end
        end
    end

    assign io.out_valid1 = vld_q;
    assign io.out_valid2 = vld_q;
    assign io.out_inp1   = inp1_q;
    assign io.out_inp2   = inp2_q;
    assign io.out_op     = op_q;
    assign io.fill1      = fill1;
    assign io.fill2      = fill2;
    assign io.pair_count = cnt_q;
endmodule

// File: tb/tb_pe_operand_joiner.sv
// Scoreboard bench: k-th accepted beat of stream 1 pairs with k-th of stream 2.
module tb_pe_operand_joiner;
    import pe_operand_joiner_pkg::*;
    localparam int DEPTH = 8;
    localparam int CNT_W = 32;

    typedef struct {
        logic [63:0] d1;
        logic [63:0] d2;
        logic [1:0]  op;
    } pair_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pe_operand_joiner_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) io ();
    pe_operand_joiner #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .io(io.slave));

    opnd1_t      q1[$];
    logic [63:0] q2[$];
    pair_t       expq[$];
    int          vld_cyc[$];
    int          acc1_cyc[$];
    int          pairs_formed = 0;
    int          n_vec = 0, n_err = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor and reference model: sample mid-cycle where everything is settled
    initial forever begin
        pair_t p;
        opnd1_t e1;
        @(negedge clk);
        if (io.out_valid1) begin
            vld_cyc.push_back(cyc);
            chk("valid2_with_valid1", io.out_valid2, 1);
            if (expq.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_pair: got %0h/%0h with nothing expected", io.out_inp1, io.out_inp2);
            end else begin
                p = expq.pop_front();
                chk("pair_inp1", io.out_inp1, p.d1);
                chk("pair_inp2", io.out_inp2, p.d2);
                chk("pair_op", io.out_op, p.op);
            end
        end else begin
            chk("valid2_idle", io.out_valid2, 0);
        end
        if (io.in1_valid && io.in1_ready) begin
            q1.push_back('{op: io.in1_op, data: io.in1_data});
            acc1_cyc.push_back(cyc);
        end
        if (io.in2_valid && io.in2_ready) q2.push_back(io.in2_data);
        while (q1.size() > 0 && q2.size() > 0) begin
            e1 = q1.pop_front();
            p.d1 = e1.data; p.op = e1.op; p.d2 = q2.pop_front();
            expq.push_back(p);
            pairs_formed++;
        end
        if (rst) begin
            q1.delete(); q2.delete(); expq.delete();
            pairs_formed = 0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        int base, abase;
        rst = 1'b1;
        io.in1_data = '0; io.in1_op = OP_ADD; io.in1_valid = 1'b0;
        io.in2_data = '0; io.in2_valid = 1'b0; io.issue_en = 1'b0;
        #1;
        chk("rst_ready1", io.in1_ready, 0);
        chk("rst_ready2", io.in2_ready, 0);
        repeat (3) step();
        chk("rst_fill1", io.fill1, 0);
        chk("rst_fill2", io.fill2, 0);
        chk("rst_valid1", io.out_valid1, 0);
        chk("rst_inp1", io.out_inp1, 0);
        chk("rst_inp2", io.out_inp2, 0);
        chk("rst_op", io.out_op, 0);
        chk("rst_count", io.pair_count, 0);
        rst = 1'b0; #1;
        chk("post_rst_ready1", io.in1_ready, 1);
        chk("post_rst_ready2", io.in2_ready, 1);

        // Lockstep streaming
        base = vld_cyc.size(); abase = acc1_cyc.size();
        io.issue_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            io.in1_valid = 1'b1; io.in1_data = 64'(i); io.in1_op = OP_ADD;
            io.in2_valid = 1'b1; io.in2_data = 64'(100 + i);
            step();
        end
        io.in1_valid = 1'b0; io.in2_valid = 1'b0;
        repeat (4) step();
        chk("ls_valid_cycles", vld_cyc.size() - base, 16);
        chk("ls_latency", vld_cyc[base] - acc1_cyc[abase], 2);
        chk("ls_contiguous", vld_cyc[base+15] - vld_cyc[base], 15);
        chk("ls_pair_count", io.pair_count, 16);

        // Stream 1 leads by five beats
        base = vld_cyc.size();
        for (int i = 0; i < 5; i++) begin
            io.in1_valid = 1'b1; io.in1_data = rnd64(); io.in1_op = 2'($urandom());
            step();
        end
        io.in1_valid = 1'b0;
        chk("skew_fill1", io.fill1, 5);
        chk("skew_no_valid", vld_cyc.size() - base, 0);
        for (int i = 0; i < 5; i++) begin
            io.in2_valid = 1'b1; io.in2_data = rnd64();
            step();
        end
        io.in2_valid = 1'b0;
        repeat (4) step();
        chk("skew_fill1_end", io.fill1, 0);
        chk("skew_fill2_end", io.fill2, 0);
        chk("skew_pairs", vld_cyc.size() - base, 5);

        // Backpressure with issue disabled
        io.issue_en = 1'b0;
        for (int i = 0; i < 11; i++) begin
            io.in1_valid = 1'b1; io.in1_data = rnd64(); io.in1_op = 2'($urandom());
            io.in2_valid = 1'b1; io.in2_data = rnd64();
            step();
        end
        chk("bp_fill1", io.fill1, DEPTH);
        chk("bp_fill2", io.fill2, DEPTH);
        chk("bp_ready1_low", io.in1_ready, 0);
        chk("bp_ready2_low", io.in2_ready, 0);
        io.in1_valid = 1'b0; io.in2_valid = 1'b0;
        base = vld_cyc.size();
        io.issue_en = 1'b1;
        step();
        chk("bp_ready1_back", io.in1_ready, 1);
        chk("bp_ready2_back", io.in2_ready, 1);
        chk("bp_fill1_7", io.fill1, DEPTH - 1);
        repeat (9) step();
        chk("bp_drain_count", vld_cyc.size() - base, 8);
        chk("bp_drain_contig", vld_cyc[base+7] - vld_cyc[base], 7);

        // Full boundary: pop at full gives no same-cycle push
        io.issue_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            io.in1_valid = 1'b1; io.in1_data = rnd64(); io.in1_op = 2'($urandom());
            io.in2_valid = (i == 0); io.in2_data = rnd64();
            step();
        end
        io.in2_valid = 1'b0;
        chk("full_fill1", io.fill1, DEPTH);
        chk("full_fill2", io.fill2, 1);
        io.in1_data = rnd64(); io.issue_en = 1'b1;
        step();
        chk("full_pop_fill1", io.fill1, DEPTH - 1);
        chk("full_pop_fill2", io.fill2, 0);
        step();
        chk("full_push_next", io.fill1, DEPTH);
        io.in1_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            io.in2_valid = 1'b1; io.in2_data = rnd64();
            step();
        end
        io.in2_valid = 1'b0;
        repeat (4) step();
        chk("full_drain_fill1", io.fill1, 0);

        // Opcode alignment
        base = vld_cyc.size();
        for (int i = 0; i < 4; i++) begin
            io.in1_valid = 1'b1; io.in1_data = rnd64(); io.in1_op = 2'(i);
            io.in2_valid = 1'b1; io.in2_data = rnd64();
            step();
        end
        io.in1_valid = 1'b0; io.in2_valid = 1'b0;
        repeat (4) step();
        chk("op_pairs", vld_cyc.size() - base, 4);
        chk("op_last", io.out_op, 2'b11);

        // Reset with entries buffered
        io.issue_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            io.in1_valid = 1'b1; io.in1_data = rnd64(); io.in1_op = 2'($urandom());
            io.in2_valid = (i < 2); io.in2_data = rnd64();
            step();
        end
        io.in1_valid = 1'b0; io.in2_valid = 1'b0;
        chk("mid_fill1", io.fill1, 3);
        chk("mid_fill2", io.fill2, 2);
        rst = 1'b1; io.issue_en = 1'b1; #1;
        chk("mid_rst_ready1", io.in1_ready, 0);
        step();
        rst = 1'b0; #1;
        base = vld_cyc.size();
        chk("mid_fill1_0", io.fill1, 0);
        chk("mid_fill2_0", io.fill2, 0);
        chk("mid_valid_0", io.out_valid1, 0);
        chk("mid_count_0", io.pair_count, 0);
        chk("mid_ready1", io.in1_ready, 1);
        chk("mid_ready2", io.in2_ready, 1);
        repeat (5) step();
        chk("mid_no_stale", vld_cyc.size() - base, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            io.in1_valid = ($urandom_range(0, 3) != 0);
            io.in1_data  = rnd64(); io.in1_op = 2'($urandom());
            io.in2_valid = ($urandom_range(0, 2) != 0);
            io.in2_data  = rnd64();
            io.issue_en  = ($urandom_range(0, 9) < 7);
            step();
        end
        io.in1_valid = 1'b0; io.in2_valid = 1'b0; io.issue_en = 1'b1;
        for (int i = 0; i < 60 && expq.size() != 0; i++) step();
        repeat (3) step();
        chk("rand_drained", expq.size(), 0);
        chk("rand_pair_count", io.pair_count, pairs_formed);
        chk("rand_fill1_left", io.fill1, q1.size());
        chk("rand_fill2_left", io.fill2, q2.size());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
